eth_rx_noc_multi_out_ctrl: RTL

Control FSM for the Ethernet RX tile's NoC egress, generalised to NUM_OUT NoC output channels and a configurable number of metadata flits.
- Per header, a CAM lookup supplies hit plus destination channel; the packet is steered to that channel or dropped.
- Drives the flit-select mux, channel-select mux and input-capture strobe of the companion datapath.
- Sits between the eth_format stage and NUM_OUT vrtoc NoC interfaces.

---
 rtl/eth_rx_tile_pkg.sv | 24 ++
 rtl/eth_rx_drop_cnt.sv | 33 +++
 rtl/eth_rx_noc_multi_out_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/eth_rx_tile_pkg.sv
// Shared types for the Ethernet RX tile NoC egress control and datapath.
package eth_rx_tile_pkg;

   // Flit source select for the egress datapath mux
   typedef enum logic [1:0] {
      SEL_HDR_FLIT  = 2'd0,
      SEL_META_FLIT = 2'd1,
      SEL_DATA_FLIT = 2'd2
   } noc_out_flit_mux_sel;

   // Packet-level state of the multi-output egress controller
   typedef enum logic [1:0] {
      READY          = 2'd0,
      META_FLIT_OUT  = 2'd1,
      DATA_FLITS_OUT = 2'd2,
      DROP_PKT       = 2'd3
   } eth_rx_multi_out_state_e;

   // Channel index width; a single channel still needs one select bit
   function automatic int chan_width(input int num_out);
      return (num_out > 1) ? $clog2(num_out) : 1;
   endfunction

endpackage

// File: rtl/eth_rx_drop_cnt.sv
// Saturating dropped-packet counter: counts up on inc and sticks at all-ones.
module eth_rx_drop_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: increment unless already saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/eth_rx_noc_multi_out_ctrl.sv
// Egress control FSM for the Ethernet RX tile: steers each packet (header,
// metadata flits, data flits) to the NoC output channel chosen by a CAM
// lookup, or drops it on a miss. Dropped-packet counting is built only when
// ETH_RX_OUT_DROP_CNT_EN is defined; otherwise drop_cnt is tied to zero.
module eth_rx_noc_multi_out_ctrl
   import eth_rx_tile_pkg::*;
#(
   parameter int NUM_OUT        = 2,
   parameter int NUM_META_FLITS = 1,
   parameter int META_IDX_W     = 2,
   parameter int DROP_CNT_W     = 16,
   localparam int CHAN_W        = chan_width(NUM_OUT)
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [NUM_OUT-1:0]      eth_rx_out_noc_vrtoc_val,
   input  logic [NUM_OUT-1:0]      noc_vrtoc_eth_rx_out_rdy,
   input  logic                    eth_format_eth_rx_out_hdr_val,
   output logic                    eth_rx_out_eth_format_hdr_rdy,
   input  logic                    eth_format_eth_rx_out_data_val,
   input  logic                    eth_format_eth_rx_out_data_last,
   output logic                    eth_rx_out_eth_format_data_rdy,
   output noc_out_flit_mux_sel     ctrl_datap_flit_sel,
   output logic [META_IDX_W-1:0]   ctrl_datap_meta_idx,
   output logic [CHAN_W-1:0]       ctrl_datap_chan_sel,
   output logic                    ctrl_datap_store_inputs,
   output logic                    ctrl_cam_rd_cam,
   input  logic                    cam_ctrl_rd_hit,
   input  logic [CHAN_W-1:0]       cam_ctrl_rd_chan,
   output logic [DROP_CNT_W-1:0]   drop_cnt
);

   localparam int PAD_W = 1 << CHAN_W;
   localparam logic [CHAN_W:0] NUM_OUT_V = (CHAN_W + 1)'(NUM_OUT);
   localparam logic [META_IDX_W-1:0] META_LAST =
      META_IDX_W'((NUM_META_FLITS > 0) ? NUM_META_FLITS - 1 : 0);

   eth_rx_multi_out_state_e state_q, state_d;
   logic [CHAN_W-1:0]       chan_q, chan_d;
   logic [META_IDX_W-1:0]   meta_cnt_q, meta_cnt_d;
   logic                    valid_hit;
   logic                    hdr_go;
   logic [PAD_W-1:0]        rdy_pad;

   // A CAM hit naming a channel that does not exist is treated as a miss
   assign valid_hit = cam_ctrl_rd_hit & ({1'b0, cam_ctrl_rd_chan} < NUM_OUT_V);

   // Ready widened to every encodable channel index so lookups never go out of range
   always_comb begin
      rdy_pad = '0;
      rdy_pad[NUM_OUT-1:0] = noc_vrtoc_eth_rx_out_rdy;
   end

   // Next-state and handshake/mux outputs for the egress packet FSM
   always_comb begin
      state_d                        = state_q;
      chan_d                         = chan_q;
      meta_cnt_d                     = meta_cnt_q;
      eth_rx_out_noc_vrtoc_val       = '0;
      eth_rx_out_eth_format_hdr_rdy  = 1'b0;
      eth_rx_out_eth_format_data_rdy = 1'b0;
      ctrl_datap_flit_sel            = SEL_HDR_FLIT;
      ctrl_datap_meta_idx            = '0;
      ctrl_datap_chan_sel            = chan_q;
      ctrl_datap_store_inputs        = 1'b0;
      ctrl_cam_rd_cam                = 1'b0;
      hdr_go                         = 1'b0;
      case (state_q)
         READY: begin
            ctrl_cam_rd_cam     = 1'b1;
            ctrl_datap_chan_sel = cam_ctrl_rd_chan;
            eth_rx_out_eth_format_hdr_rdy = valid_hit ? rdy_pad[cam_ctrl_rd_chan] : 1'b1;
            if (valid_hit) begin
               eth_rx_out_noc_vrtoc_val[cam_ctrl_rd_chan] = eth_format_eth_rx_out_hdr_val;
            end
            hdr_go = eth_format_eth_rx_out_hdr_val & eth_rx_out_eth_format_hdr_rdy;
            if (hdr_go) begin
               ctrl_datap_store_inputs = 1'b1;
               chan_d = cam_ctrl_rd_chan;
               if (!valid_hit) begin
                  state_d = DROP_PKT;
               end else if (NUM_META_FLITS > 0) begin
                  state_d = META_FLIT_OUT;
               end else begin
                  state_d = DATA_FLITS_OUT;
               end
            end
         end
         META_FLIT_OUT: begin
            ctrl_datap_flit_sel = SEL_META_FLIT;
            ctrl_datap_meta_idx = meta_cnt_q;
            eth_rx_out_noc_vrtoc_val[chan_q] = 1'b1;
            if (rdy_pad[chan_q]) begin
               if (meta_cnt_q == META_LAST) begin
                  meta_cnt_d = '0;
                  state_d    = DATA_FLITS_OUT;
               end else begin
                  meta_cnt_d = meta_cnt_q + 1'b1;
               end
            end
         end
         DATA_FLITS_OUT: begin
            ctrl_datap_flit_sel = SEL_DATA_FLIT;
            eth_rx_out_noc_vrtoc_val[chan_q] = eth_format_eth_rx_out_data_val;
            eth_rx_out_eth_format_data_rdy   = rdy_pad[chan_q];
            if (eth_format_eth_rx_out_data_val && rdy_pad[chan_q] &&
                eth_format_eth_rx_out_data_last) begin
               state_d = READY;
            end
         end
         DROP_PKT: begin
            eth_rx_out_eth_format_data_rdy = 1'b1;
            if (eth_format_eth_rx_out_data_val && eth_format_eth_rx_out_data_last) begin
               state_d = READY;
            end
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   // State, captured channel and metadata index registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= READY;
         chan_q     <= '0;
         meta_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         chan_q     <= chan_d;
         meta_cnt_q <= meta_cnt_d;
      end
   end

`ifdef ETH_RX_OUT_DROP_CNT_EN
   logic drop_inc;

   // A miss header is always accepted, so every header seen on a miss is a drop
   assign drop_inc = (state_q == READY) & eth_format_eth_rx_out_hdr_val & ~valid_hit;

   eth_rx_drop_cnt #(
      .W(DROP_CNT_W)
   ) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (drop_cnt)
   );
`else
   assign drop_cnt = '0;
`endif

endmodule
